cordic_scheduler: RTL and testbench

- Time-shares one non-pipelined `cordic` sine/cosine engine between NUM_CH requesters, e.g. NCO channels in the RF frontend.
- Accepts angle requests, arbitrates round-robin, and sequences the engine's enable/valid handshake.
- Returns each result to the requester that owns it.
- Sits between the per-channel phase accumulators and the single `cordic` instance.

---
 rtl/cordic_scheduler_pkg.sv | 22 ++
 rtl/cordic_scheduler_if.sv | 26 ++
 rtl/cordic_rr_arbiter.sv | 29 ++
 rtl/cordic_scheduler.sv | 116 +++++++++++
 tb/tb_cordic_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_scheduler_pkg.sv
// Shared definitions for the cordic scheduler: FSM encoding, default widths
// matching the cordic engine, and an index-width helper.
package cordic_scheduler_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ANGLE_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } sched_state_t;

  // Never returns 0 so that single-entry indices still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester-side bus of the cordic scheduler: per-channel angle requests in,
// one-hot result strobes plus shared sine/cosine out.
interface cordic_scheduler_if
  import cordic_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH*ANGLE_WIDTH-1:0] req_angle;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_sine;
  logic [DATA_WIDTH-1:0]         rsp_cosine;

  modport master (
    output req_valid, req_angle,
    input  req_ready, rsp_valid, rsp_sine, rsp_cosine
  );

  modport slave (
    input  req_valid, req_angle,
    output req_ready, rsp_valid, rsp_sine, rsp_cosine
  );
endinterface

// File: rtl/cordic_rr_arbiter.sv
// Combinational rotate-priority encoder: first request at or after ptr+1
// (with wrap) wins; returns one-hot grant, its index and an any-request flag.
module cordic_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end
endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one non-pipelined cordic engine between NUM_CH requesters with
// round-robin arbitration, a timeout on the engine, and per-owner result return.
module cordic_scheduler
  import cordic_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int TIMEOUT     = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_scheduler_if.slave      s_req,
  output logic                   o_cordic_enable,
  output logic [ANGLE_WIDTH-1:0] o_cordic_angle,
  input  logic                   i_cordic_ready,
  input  logic                   i_cordic_valid,
  input  logic [DATA_WIDTH-1:0]  i_cordic_sine,
  input  logic [DATA_WIDTH-1:0]  i_cordic_cosine,
  output logic                   o_busy,
  output logic                   o_timeout_err
);
  localparam int IDX_W = clog2(NUM_CH);
  localparam int CNT_W = clog2(TIMEOUT + 1);

  sched_state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_ptr, r_owner;
  logic [CNT_W-1:0]       r_cnt;
  logic [ANGLE_WIDTH-1:0] r_angle;
  logic [NUM_CH-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_sine, r_rsp_cosine;
  logic                   r_tmo;

  logic [NUM_CH-1:0]      w_gnt;
  logic [IDX_W-1:0]       w_gidx;
  logic                   w_any, w_accept, w_expire;
  logic [ANGLE_WIDTH-1:0] w_angle_sel;

  cordic_rr_arbiter #(.N(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .i_req (s_req.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  always_comb begin
    w_angle_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_gnt[i]) w_angle_sel = s_req.req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rst_n gate keeps req_ready low while reset is held.
        if (rst_n && w_any && i_cordic_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_cordic_valid) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_expire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= IDX_W'(NUM_CH - 1);
      r_owner      <= '0;
      r_cnt        <= '0;
      r_angle      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_sine   <= '0;
      r_rsp_cosine <= '0;
      r_tmo        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= '0;
      r_tmo       <= w_expire;
      if (w_accept) begin
        r_angle <= w_angle_sel;
        r_owner <= w_gidx;
        r_ptr   <= w_gidx;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_WAIT && i_cordic_valid) begin
        r_rsp_sine   <= i_cordic_sine;
        r_rsp_cosine <= i_cordic_cosine;
        r_rsp_valid  <= NUM_CH'(1) << r_owner;
      end
    end
  end

  assign s_req.req_ready  = w_accept ? w_gnt : '0;
  assign s_req.rsp_valid  = r_rsp_valid;
  assign s_req.rsp_sine   = r_rsp_sine;
  assign s_req.rsp_cosine = r_rsp_cosine;
  assign o_cordic_enable  = (r_state == S_ISSUE);
  assign o_cordic_angle   = r_angle;
  assign o_busy           = (r_state != S_IDLE);
  assign o_timeout_err    = r_tmo;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a behavioural 14-cycle engine model
// (sine = angle ^ 5A5A, cosine = ~angle) and a manual engine override.
module tb_cordic_scheduler;
  localparam int NCH = 4;
  localparam int TMO = 31;
  localparam int LAT = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_scheduler_if #(.NUM_CH(NCH), .ANGLE_WIDTH(16), .DATA_WIDTH(16)) bus ();

  logic        cordic_enable, cordic_ready, cordic_valid, busy, timeout_err;
  logic [15:0] cordic_angle, cordic_sine, cordic_cosine;

  // Engine model
  logic        eng_auto = 1'b1;
  logic        m_ready = 1'b1, m_valid = 1'b0;
  logic [15:0] m_sine = '0, m_cos = '0;
  logic        e_ready, e_valid;
  logic [15:0] e_sin, e_cos, e_ang;
  int          e_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ready <= 1'b1; e_valid <= 1'b0; e_cnt <= 0;
      e_sin <= '0; e_cos <= '0; e_ang <= '0;
    end else begin
      e_valid <= 1'b0;
      if (cordic_enable && e_ready) begin
        e_ready <= 1'b0; e_cnt <= LAT; e_ang <= cordic_angle;
      end else if (e_cnt != 0) begin
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1) begin
          e_valid <= 1'b1; e_ready <= 1'b1;
          e_sin <= e_ang ^ 16'h5A5A; e_cos <= ~e_ang;
        end
      end
    end
  end

  assign cordic_ready  = eng_auto ? e_ready : m_ready;
  assign cordic_valid  = eng_auto ? e_valid : m_valid;
  assign cordic_sine   = eng_auto ? e_sin   : m_sine;
  assign cordic_cosine = eng_auto ? e_cos   : m_cos;

  cordic_scheduler #(.NUM_CH(NCH), .DATA_WIDTH(16), .ANGLE_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_req           (bus),
    .o_cordic_enable (cordic_enable),
    .o_cordic_angle  (cordic_angle),
    .i_cordic_ready  (cordic_ready),
    .i_cordic_valid  (cordic_valid),
    .i_cordic_sine   (cordic_sine),
    .i_cordic_cosine (cordic_cosine),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_angle(input int ch, input logic [15:0] a);
    bus.req_angle[ch*16 +: 16] = a;
  endtask

  logic [15:0] exp_sin [4] = '{16'h5A5A, 16'h4A5A, 16'h7A5A, 16'h6A5A};
  logic [15:0] exp_cos [4] = '{16'hFFFF, 16'hEFFF, 16'hDFFF, 16'hCFFF};

  initial begin
    int w, viol;
    bus.req_valid = '0;
    bus.req_angle = '0;

    // Reset state, with a request pending during reset
    bus.req_valid = 4'b0001;
    tick(); tick();
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_ready",   32'(bus.req_ready), 32'h0);
    chk("rst_rsp",     32'(bus.rsp_valid), 32'h0);
    chk("rst_enable",  32'(cordic_enable), 32'h0);
    chk("rst_angle",   32'(cordic_angle), 32'h0);
    chk("rst_sine",    32'(bus.rsp_sine), 32'h0);
    chk("rst_tmo",     32'(timeout_err), 32'h0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request on ch2
    set_angle(2, 16'h2000);
    bus.req_valid = 4'b0100; #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0; #1;
    chk("single_enable", 32'(cordic_enable), 32'h1);
    chk("single_angle",  32'(cordic_angle), 32'h2000);
    chk("single_busy",   32'(busy), 32'h1);
    tick();
    chk("single_enable_1cyc", 32'(cordic_enable), 32'h0);
    w = 0;
    while (!cordic_valid && w < 100) begin tick(); w++; end
    chk("single_valid_seen", 32'(cordic_valid), 32'h1);
    chk("single_no_early_rsp", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("single_rsp", 32'(bus.rsp_valid), 32'h4);
    chk("single_sine", 32'(bus.rsp_sine), 32'h7A5A);
    chk("single_cos",  32'(bus.rsp_cosine), 32'hDFFF);
    tick();
    chk("single_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
    chk("single_sine_hold", 32'(bus.rsp_sine), 32'h7A5A);

    // Round robin from reset: 0,1,2,3,0
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int c = 0; c < 4; c++) set_angle(c, 16'(c * 16'h1000));
    bus.req_valid = 4'b1111; #1;
    viol = 0;
    for (int k = 0; k < 5; k++) begin
      int ch;
      ch = k % 4;
      w = 0;
      while (bus.req_ready == '0 && w < 50) begin tick(); w++; end
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << ch));
      tick();
      chk("rr_angle", 32'(cordic_angle), 32'(ch * 16'h1000));
      w = 0;
      while (bus.rsp_valid == '0 && w < 50) begin
        if (busy && bus.req_ready != '0) viol++;
        tick(); w++;
      end
      chk("rr_rsp",  32'(bus.rsp_valid), 32'(1 << ch));
      chk("rr_sine", 32'(bus.rsp_sine), 32'(exp_sin[ch]));
      chk("rr_cos",  32'(bus.rsp_cosine), 32'(exp_cos[ch]));
    end
    bus.req_valid = '0;
    tick();
    chk("rr_one_in_flight", 32'(viol), 32'h0);

    // Angle changes after acceptance
    set_angle(1, 16'h1111);
    bus.req_valid = 4'b0010; #1;
    chk("hold_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    set_angle(1, 16'h2222); #1;
    chk("hold_enable", 32'(cordic_enable), 32'h1);
    chk("hold_angle",  32'(cordic_angle), 32'h1111);
    w = 0;
    while (bus.rsp_valid == '0 && w < 50) begin tick(); w++; end
    chk("hold_rsp",  32'(bus.rsp_valid), 32'h2);
    chk("hold_sine", 32'(bus.rsp_sine), 32'h4B4B);
    tick();

    // Timeout: engine never answers
    eng_auto = 1'b0; m_ready = 1'b1; m_valid = 1'b0;
    bus.req_valid = 4'b0001; #1;
    chk("tmo_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0; m_ready = 1'b0;
    tick();
    viol = 0;
    for (int c = 1; c < TMO; c++) begin
      tick();
      if (timeout_err || bus.rsp_valid != '0 || !busy) viol++;
    end
    chk("tmo_early", 32'(viol), 32'h0);
    tick();
    chk("tmo_pulse", 32'(timeout_err), 32'h1);
    chk("tmo_no_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("tmo_idle", 32'(busy), 32'h0);
    bus.req_valid = 4'b0100;
    m_valid = 1'b1; m_sine = 16'h1234; m_cos = 16'hABCD; #1;
    chk("tmo_wait_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("tmo_pulse_1cyc", 32'(timeout_err), 32'h0);
    m_valid = 1'b0;
    tick();
    chk("late_valid_no_rsp", 32'(bus.rsp_valid), 32'h0);
    m_ready = 1'b1; #1;
    chk("tmo_regrant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0; m_ready = 1'b0;
    tick(); tick(); tick();
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    chk("manual_rsp",  32'(bus.rsp_valid), 32'h4);
    chk("manual_sine", 32'(bus.rsp_sine), 32'h1234);
    chk("manual_cos",  32'(bus.rsp_cosine), 32'hABCD);

    // Ready low blocks the grant
    m_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick(); tick(); tick();
    chk("notready_blocked", 32'(bus.req_ready), 32'h0);
    m_ready = 1'b1; #1;
    chk("notready_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    for (int c = 0; c < 20; c++) tick();
    eng_auto = 1'b1;

    // Reset during WAIT
    bus.req_valid = 4'b1000; #1;
    chk("rstw_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    tick(); tick(); tick();
    chk("rstw_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    bus.req_valid = 4'b1001; #1;
    chk("rstw_busy",   32'(busy), 32'h0);
    chk("rstw_ready0", 32'(bus.req_ready), 32'h0);
    chk("rstw_angle",  32'(cordic_angle), 32'h0);
    chk("rstw_sine",   32'(bus.rsp_sine), 32'h0);
    bus.req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.rsp_valid != '0 || timeout_err) viol++;
    end
    chk("rstw_no_rsp", 32'(viol), 32'h0);
    bus.req_valid = 4'b1001; #1;
    chk("rstw_ch0_first", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
